// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone GPIO block with edge-triggered interrupts, enabled by defining WB_GPIO_IRQ_EN
module wb_gpio #(
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  irq_o
);
    logic                  req, wr, rd;
    logic [3:0]            off;
    logic [31:0]           bmask;
    logic [GPIO_WIDTH-1:0] wmask, wdata;
    logic                  ack_d, ack_q, err_d, err_q;
    logic [31:0]           dat_d, dat_q;
    logic [GPIO_WIDTH-1:0] out_d, out_q, dir_d, dir_q;
    logic [GPIO_WIDTH-1:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic                  unused_ok;
`ifdef WB_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] en_d, en_q, edge_d, edge_q, stat_d, stat_q, prev_d, prev_q, hit;
    logic                  irq_d, irq_q;
`endif

    assign unused_ok  = ^{wb_adr_i, wb_dat_i, bmask};
    assign wb_stall_o = 1'b0;
    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign gpio_o     = out_q;
    assign gpio_oe_o  = dir_q;

    // Decode the request; offsets 0x20-0x3C are unmapped and never write
    always_comb begin
        req   = wb_cyc_i & wb_stb_i;
        off   = wb_adr_i[5:2];
        wr    = req & wb_we_i & ~off[3];
        rd    = req & ~wb_we_i & ~off[3];
        bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wmask = bmask[GPIO_WIDTH-1:0];
        wdata = wb_dat_i[GPIO_WIDTH-1:0] & wmask;
    end

    // Next-state for bus response, output registers, synchronizer and read data
    always_comb begin
        ack_d   = req & ~off[3];
        err_d   = req & off[3];
        sync1_d = gpio_i;
        sync2_d = sync1_q;
        out_d   = (wr && off == 4'd1) ? (out_q & ~wmask) | wdata :
                  (wr && off == 4'd3) ? out_q | wdata :
                  (wr && off == 4'd4) ? out_q & ~wdata : out_q;
        dir_d   = (wr && off == 4'd2) ? (dir_q & ~wmask) | wdata : dir_q;
        dat_d   = '0;
        if (rd) begin
            case (off[2:0])
                3'd0:    dat_d[GPIO_WIDTH-1:0] = sync2_q;
                3'd1:    dat_d[GPIO_WIDTH-1:0] = out_q;
                3'd2:    dat_d[GPIO_WIDTH-1:0] = dir_q;
`ifdef WB_GPIO_IRQ_EN
                3'd5:    dat_d[GPIO_WIDTH-1:0] = en_q;
                3'd6:    dat_d[GPIO_WIDTH-1:0] = edge_q;
                3'd7:    dat_d[GPIO_WIDTH-1:0] = stat_q;
`endif
                default: dat_d = '0;
            endcase
        end
    end

    // Core state registers with asynchronous reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef WB_GPIO_IRQ_EN
    // Edge detect against the previous sample; a fresh edge wins over a same-cycle clear
    always_comb begin
        prev_d = sync2_q;
        hit    = (edge_q & sync2_q & ~prev_q) | (~edge_q & ~sync2_q & prev_q);
        en_d   = (wr && off == 4'd5) ? (en_q & ~wmask) | wdata : en_q;
        edge_d = (wr && off == 4'd6) ? (edge_q & ~wmask) | wdata : edge_q;
        stat_d = (stat_q & ~((wr && off == 4'd7) ? wdata : '0)) | hit;
        irq_d  = |(stat_q & en_q);
    end

    // Interrupt state registers with asynchronous reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q   <= '0;
            edge_q <= '0;
            stat_q <= '0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            edge_q <= edge_d;
            stat_q <= stat_d;
            prev_q <= prev_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_gpio.sv
// tb_wb_gpio: directed scoreboard bench for wb_gpio
module tb_wb_gpio;
    logic        wb_clk_i, wb_rst_i, wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o, wb_stall_o, irq_o;
    logic [15:0] gpio_i, gpio_o, gpio_oe_o;

    int checks = 0;
    int errors = 0;

    logic        q_err[$];
    logic        q_rd[$];
    logic [31:0] q_dat[$];
    string       q_tag[$];

    wb_gpio #(.GPIO_WIDTH(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic issue(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_dat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        q_err.push_back(adr[5:2] >= 4'd8);
        q_rd.push_back(!we);
        q_dat.push_back(exp_dat);
        q_tag.push_back(tag);
    endtask

    task automatic resp();
        logic        e, r;
        logic [31:0] d;
        string       t;
        e = q_err.pop_front();
        r = q_rd.pop_front();
        d = q_dat.pop_front();
        t = q_tag.pop_front();
        chk({t, "_ack"}, 32'(wb_ack_o), 32'(!e));
        chk({t, "_err"}, 32'(wb_err_o), 32'(e));
        if (r && !e) chk({t, "_dat"}, wb_dat_o, d);
    endtask

    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_dat);
        issue(tag, we, adr, dat, sel, exp_dat);
        step();
        idle();
        resp();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        idle();
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        gpio_i   = '0;
        step(); step(); step();
        chk("rst_gpio_o", 32'(gpio_o), 0);
        chk("rst_gpio_oe", 32'(gpio_oe_o), 0);
        chk("rst_ack", 32'(wb_ack_o), 0);
        chk("rst_err", 32'(wb_err_o), 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_irq", 32'(irq_o), 0);
        chk("stall", 32'(wb_stall_o), 0);
        wb_rst_i = 1'b0;
        step(); step();
        chk("post_rst_irq", 32'(irq_o), 0);
        gpio_i = 16'h5A3C;

        xfer("out_wr", 1, 32'h04, 32'h0000A5A5, 4'hF, 0);
        step();
        chk("out_pins", 32'(gpio_o), 32'hA5A5);
        xfer("out_rd", 0, 32'h04, 0, 4'hF, 32'h0000A5A5);
        xfer("out_lane0", 1, 32'h04, 32'h00001234, 4'h1, 0);
        xfer("out_lane_rd", 0, 32'h04, 0, 4'hF, 32'h0000A534);

        xfer("out_f0", 1, 32'h04, 32'h000000F0, 4'hF, 0);
        xfer("set", 1, 32'h0C, 32'h0000000F, 4'hF, 0);
        xfer("clr", 1, 32'h10, 32'h00000030, 4'hF, 0);
        xfer("setclr_rd", 0, 32'h04, 0, 4'hF, 32'h000000CF);
        xfer("set_rd_zero", 0, 32'h0C, 0, 4'hF, 0);
        chk("setclr_pins", 32'(gpio_o), 32'h00CF);

        xfer("dir_wr", 1, 32'h08, 32'hFFFFFFFF, 4'hF, 0);
        xfer("dir_rd_hi0", 0, 32'h08, 0, 4'hF, 32'h0000FFFF);
        chk("dir_pins", 32'(gpio_oe_o), 32'hFFFF);

        xfer("in_wr_ign", 1, 32'h00, 32'h0000FFFF, 4'hF, 0);
        xfer("in_rd", 0, 32'h00, 0, 4'hF, 32'h00005A3C);
        xfer("out_after_in_wr", 0, 32'h04, 0, 4'hF, 32'h000000CF);

        gpio_i = 16'h1111;
        issue("in_b2b0", 0, 32'h00, 0, 4'hF, 32'h00005A3C);
        step();
        resp();
        issue("in_b2b1", 0, 32'h00, 0, 4'hF, 32'h00005A3C);
        step();
        resp();
        issue("in_b2b2", 0, 32'h00, 0, 4'hF, 32'h00001111);
        step();
        idle();
        resp();
        step();
        chk("b2b_end_ack", 32'(wb_ack_o), 0);

        xfer("err_rd24", 0, 32'h24, 0, 4'hF, 0);
        xfer("err_wr24", 1, 32'h24, 32'h0000FFFF, 4'hF, 0);
        xfer("err_nochg", 0, 32'h04, 0, 4'hF, 32'h000000CF);

`ifdef WB_GPIO_IRQ_EN
        xfer("stat_clr_all", 1, 32'h1C, 32'h0000FFFF, 4'hF, 0);
        xfer("stat_zero", 0, 32'h1C, 0, 4'hF, 0);
        xfer("edge_wr", 1, 32'h18, 32'h8, 4'hF, 0);
        xfer("en_wr", 1, 32'h14, 32'h8, 4'hF, 0);
        xfer("edge_rd", 0, 32'h18, 0, 4'hF, 32'h8);
        xfer("en_rd", 0, 32'h14, 0, 4'hF, 32'h8);
        gpio_i = 16'h1119;
        step(); step(); step();
        chk("irq_not_yet", 32'(irq_o), 0);
        step();
        chk("irq_set", 32'(irq_o), 1);
        xfer("stat_rise", 0, 32'h1C, 0, 4'hF, 32'h8);
        xfer("w1c3", 1, 32'h1C, 32'h8, 4'hF, 0);
        step();
        chk("irq_clr", 32'(irq_o), 0);
        xfer("stat_cleared", 0, 32'h1C, 0, 4'hF, 0);

        gpio_i = 16'h1109;
        step(); step(); step(); step();
        xfer("stat_fall_unmasked", 0, 32'h1C, 0, 4'hF, 32'h10);
        chk("irq_masked", 32'(irq_o), 0);
        xfer("w1c_wrong_lane", 1, 32'h1C, 32'h10, 4'h2, 0);
        xfer("stat_kept", 0, 32'h1C, 0, 4'hF, 32'h10);
        xfer("w1c4", 1, 32'h1C, 32'h10, 4'h1, 0);
        xfer("stat_zero2", 0, 32'h1C, 0, 4'hF, 0);

        gpio_i = 16'h1101;
        step(); step(); step(); step();
        xfer("no_fall_flag", 0, 32'h1C, 0, 4'hF, 0);
        gpio_i = 16'h1109;
        step(); step();
        issue("w1c_race", 1, 32'h1C, 32'h8, 4'hF, 0);
        step();
        idle();
        resp();
        xfer("race_kept", 0, 32'h1C, 0, 4'hF, 32'h8);
        step();
        chk("race_irq", 32'(irq_o), 1);
        xfer("w1c_race_end", 1, 32'h1C, 32'h8, 4'hF, 0);
`else
        xfer("en_wr_ign", 1, 32'h14, 32'h0000FFFF, 4'hF, 0);
        xfer("edge_wr_ign", 1, 32'h18, 32'h0000FFFF, 4'hF, 0);
        xfer("en_rd0", 0, 32'h14, 0, 4'hF, 0);
        xfer("edge_rd0", 0, 32'h18, 0, 4'hF, 0);
        xfer("stat_rd0", 0, 32'h1C, 0, 4'hF, 0);
        gpio_i = 16'h0000;
        step(); step(); step(); step();
        chk("irq_tied", 32'(irq_o), 0);
`endif

        gpio_i = 16'h0000;
        step(); step(); step();
        chk("pre_rst_oe", 32'(gpio_oe_o), 32'hFFFF);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h04;
        wb_dat_i = 32'h1234;
        wb_sel_i = 4'hF;
        #3;
        wb_rst_i = 1'b1;
        #1;
        chk("async_oe", 32'(gpio_oe_o), 0);
        chk("async_out", 32'(gpio_o), 0);
        chk("async_ack", 32'(wb_ack_o), 0);
        idle();
        step(); step();
        wb_rst_i = 1'b0;
        step();
        chk("rel_ack0", 32'(wb_ack_o), 0);
        chk("rel_err0", 32'(wb_err_o), 0);
        step();
        chk("rel_ack1", 32'(wb_ack_o), 0);
        xfer("rel_out", 0, 32'h04, 0, 4'hF, 0);
        xfer("rel_dir", 0, 32'h08, 0, 4'hF, 0);
`ifdef WB_GPIO_IRQ_EN
        xfer("rel_stat", 0, 32'h1C, 0, 4'hF, 0);
`endif
        chk("rel_irq", 32'(irq_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
